// File: rtl/reg_cmd_sequencer.sv
// Table-driven register-bus master: plays back a programmable list of writes,
// read-polls and timed waits, with poll timeout, error capture and abort.
module reg_cmd_sequencer #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumCmds   = 16,
  parameter int unsigned CntWidth  = 16,
  parameter int unsigned PollGap   = 2,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned PcWidth   = $clog2(NumCmds + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic                                abort_i,
  input  logic [CntWidth-1:0]                 poll_max_i,
  input  logic [NumCmds-1:0][1:0]             cmd_op_i,
  input  logic [NumCmds-1:0][AddrWidth-1:0]   cmd_addr_i,
  input  logic [NumCmds-1:0][DataWidth-1:0]   cmd_data_i,
  input  logic [NumCmds-1:0][DataWidth-1:0]   cmd_mask_i,
  input  logic [NumCmds-1:0][StrbWidth-1:0]   cmd_strb_i,
  output logic                                reg_valid_o,
  output logic                                reg_write_o,
  output logic [AddrWidth-1:0]                reg_addr_o,
  output logic [DataWidth-1:0]                reg_wdata_o,
  output logic [StrbWidth-1:0]                reg_wstrb_o,
  input  logic                                reg_ready_i,
  input  logic [DataWidth-1:0]                reg_rdata_i,
  input  logic                                reg_error_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                err_o,
  output logic [1:0]                          err_code_o,
  output logic [PcWidth-1:0]                  err_idx_o,
  output logic [DataWidth-1:0]                last_rdata_o
);

  localparam int unsigned IdxWidth = (NumCmds > 1) ? $clog2(NumCmds) : 1;
  localparam logic [PcWidth-1:0]  PcEnd   = PcWidth'(NumCmds);
  localparam logic [PcWidth-1:0]  PcOne   = PcWidth'(1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] GapLoad = CntWidth'(PollGap);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_GAP, S_WAIT, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_END   = 2'b00,
    OP_WRITE = 2'b01,
    OP_POLL  = 2'b10,
    OP_WAIT  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_BUS     = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  state_e               state_q, state_d;
  logic [PcWidth-1:0]   pc_q, pc_d;
  logic [CntWidth-1:0]  attempt_q, attempt_d;
  // One counter serves both WAIT and GAP; the two states never overlap.
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [DataWidth-1:0] last_rdata_q, last_rdata_d;
  err_e                 err_code_q, err_code_d;
  logic [PcWidth-1:0]   err_idx_q, err_idx_d;

  logic                 pc_end;
  logic [IdxWidth-1:0]  idx;
  op_e                  cur_op;
  logic [AddrWidth-1:0] cur_addr;
  logic [DataWidth-1:0] cur_data;
  logic [DataWidth-1:0] cur_mask;
  logic [StrbWidth-1:0] cur_strb;
  logic [CntWidth-1:0]  wait_cnt;
  logic [CntWidth-1:0]  attempt_inc;
  logic [PcWidth-1:0]   pc_inc;
  logic                 poll_hit;

  // The index is forced to 0 once pc runs past the table so the lookup never
  // goes out of range; FETCH routes pc_end to DONE before using the entry.
  assign pc_end   = (pc_q >= PcEnd);
  assign idx      = pc_end ? '0 : pc_q[IdxWidth-1:0];
  assign cur_op   = op_e'(cmd_op_i[idx]);
  assign cur_addr = cmd_addr_i[idx];
  assign cur_data = cmd_data_i[idx];
  assign cur_mask = cmd_mask_i[idx];
  assign cur_strb = cmd_strb_i[idx];
  assign wait_cnt = cur_data[CntWidth-1:0];
  assign poll_hit = (((reg_rdata_i ^ cur_data) & cur_mask) == '0);

  assign attempt_inc = (attempt_q == '1) ? attempt_q : attempt_q + CntOne;
  assign pc_inc      = pc_end ? pc_q : pc_q + PcOne;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      attempt_q    <= '0;
      cnt_q        <= '0;
      last_rdata_q <= '0;
      err_code_q   <= ERR_NONE;
      err_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      attempt_q    <= attempt_d;
      cnt_q        <= cnt_d;
      last_rdata_q <= last_rdata_d;
      err_code_q   <= err_code_d;
      err_idx_q    <= err_idx_d;
    end
  end

  always_comb begin
    // NOTE: every next-state variable takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    attempt_d    = attempt_q;
    cnt_d        = cnt_q;
    last_rdata_d = last_rdata_q;
    err_code_d   = err_code_q;
    err_idx_d    = err_idx_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          state_d    = S_FETCH;
          pc_d       = '0;
          attempt_d  = '0;
          err_code_d = ERR_NONE;
          err_idx_d  = '0;
        end
      end

      S_FETCH: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (pc_end || cur_op == OP_END) begin
          state_d = S_DONE;
        end else if (cur_op == OP_WAIT) begin
          if (wait_cnt == '0) begin
            pc_d = pc_inc;
          end else begin
            cnt_d   = wait_cnt;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end

      // The request is held until the slave completes it, even under abort.
      S_ISSUE: begin
        if (reg_ready_i) begin
          if (abort_i) begin
            state_d = S_IDLE;
          end else if (reg_error_i) begin
            state_d    = S_ERR;
            err_code_d = ERR_BUS;
            err_idx_d  = pc_q;
          end else if (cur_op == OP_WRITE) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            last_rdata_d = reg_rdata_i;
            if (poll_hit) begin
              pc_d      = pc_inc;
              attempt_d = '0;
              state_d   = S_FETCH;
            end else begin
              attempt_d = attempt_inc;
              if (poll_max_i != '0 && attempt_inc == poll_max_i) begin
                state_d    = S_ERR;
                err_code_d = ERR_TIMEOUT;
                err_idx_d  = pc_q;
              end else if (PollGap == 0) begin
                state_d = S_ISSUE;
              end else begin
                cnt_d   = GapLoad;
                state_d = S_GAP;
              end
            end
          end
        end
      end

      S_GAP: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q <= CntOne) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      // Leaving on a count of 1 makes a WAIT of N occupy exactly N cycles.
      S_WAIT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q <= CntOne) begin
          cnt_d   = '0;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    reg_valid_o = 1'b0;
    reg_write_o = 1'b0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    reg_wstrb_o = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;

    unique case (state_q)
      S_FETCH, S_GAP, S_WAIT: busy_o = 1'b1;
      S_ISSUE: begin
        busy_o      = 1'b1;
        reg_valid_o = 1'b1;
        reg_write_o = (cur_op == OP_WRITE);
        reg_addr_o  = cur_addr;
        reg_wdata_o = cur_data;
        reg_wstrb_o = (cur_op == OP_WRITE) ? cur_strb : '0;
      end
      S_DONE:  done_o = 1'b1;
      S_ERR:   err_o  = 1'b1;
      default: ;
    endcase
  end

  assign err_code_o   = err_code_q;
  assign err_idx_o    = err_idx_q;
  assign last_rdata_o = last_rdata_q;

endmodule
